mips_muldiv_unit: RTL

- Multi-cycle, parametrised multiply/divide unit that owns the HI/LO architectural registers.
- Successor to the single-cycle combinational MULT/MULTU/DIV/DIVU path in the ALU. Adds iterative shift-add/restoring datapath, start/busy/done handshake, MTHI/MTLO writes, flush, and defined divide-by-zero/overflow results.
- Sits beside the ALU in EX; the control unit stalls on busy and reads HI/LO for MFHI/MFLO.

---
 rtl/mips_muldiv_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// CALC  | one multiply/divide iteration per cycle
// FIXUP | sign correction, HI/LO write, done pulse
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t               state;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplr;

  logic                 signed_op;
  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last_iter;

  always_comb begin
    signed_op = ~op[0] & ~op[2];
    rs_neg    = signed_op & rs_content[WIDTH-1];
    rt_neg    = signed_op & rt_content[WIDTH-1];
    rs_mag    = rs_neg ? -rs_content : rs_content;
    rt_mag    = rt_neg ? -rt_content : rt_content;
    // Divide: acc holds {remainder, dividend/quotient shift register}
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand[WIDTH-1:0]};
    mul_sum   = acc + (mplr[0] ? mcand : '0);
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign last_iter = (cnt == '0) || (!is_div && (mplr[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state  <= S_CALC;
                busy   <= 1'b1;
                cnt    <= CNT_W'(WIDTH - 1);
                is_div <= op[1];
                neg_q  <= rs_neg ^ rt_neg;
                if (op[1]) begin
                  acc      <= {{WIDTH{1'b0}}, rs_mag};
                  mcand    <= {{WIDTH{1'b0}}, rt_mag};
                  mplr     <= '0;
                  neg_r    <= rs_neg;
                  div_zero <= (rt_content == '0);
                end else begin
                  acc      <= '0;
                  mcand    <= {{WIDTH{1'b0}}, rs_mag};
                  mplr     <= rt_mag;
                  neg_r    <= 1'b0;
                  div_zero <= 1'b0;
                end
              end
              OP_MTHI: HI <= rs_content;
              OP_MTLO: LO <= rs_content;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc <= div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
              acc   <= mul_sum;
              mcand <= mcand << 1;
              mplr  <= mplr >> 1;
            end
            cnt <= cnt - 1'b1;
            if (last_iter) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              {HI, LO} <= prod_fix;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
